mood_display_sequencer: RTL and testbench

Downstream presentation stage for the mimosa's emotion output. It filters the 8-bit emotion code so brief flicker is ignored, plays an 8-step LED sweep whenever a new mood is committed, and dims the LEDs while the plant is asleep. It also reports every committed mood change to a host logger over a valid/ready handshake.

---
 rtl/mood_display_sequencer_if.sv | 27 ++
 rtl/mood_display_sequencer.sv | 132 +++++++++++++
 tb/tb_mood_display_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mood_display_sequencer_if.sv
// Mood-change event channel from the display sequencer to the host logger.
//
// Handshake: the master raises evt_valid with evt_data; the event is
// accepted on the rising clk edge where evt_valid and evt_ready are both 1.
// evt_data is held while evt_valid=1 unless a newer mood overwrites it, in
// which case the master sets the sticky evt_drop flag. evt_valid may rise
// while evt_ready is already high.
interface mood_display_sequencer_if;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_ready;
    logic       evt_drop;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/mood_display_sequencer.sv
// Presentation stage for the emotion code: debounces the code over ticks,
// plays an 8-step LED sweep on every committed mood change, dims the LEDs
// to 1/4 duty while asleep, and reports committed moods to a logger.
module mood_display_sequencer #(
    parameter int STABLE_TICKS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic [7:0]                      emotion_in,
    input  logic                            awake,
    output logic [7:0]                      led_out,
    output logic [7:0]                      mood,
    mood_display_sequencer_if.master        evt,
    output logic                            dbg_sweep,
    output logic [2:0]                      dbg_idx
);

    localparam logic [3:0] SC_MAX    = 4'(STABLE_TICKS);
    localparam logic [3:0] SC_COMMIT = 4'(STABLE_TICKS - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        SWEEP = 1'b1
    } disp_state_t;

    logic [7:0]  cand;
    logic [3:0]  sc;
    logic        commit;
    disp_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  pwm;
    logic [7:0]  raw;

    // A commit needs the value to have been seen on STABLE_TICKS ticks in a
    // row (loading tick included) and to differ from the shown mood.
    assign commit = tick && (emotion_in == cand) && (sc == SC_COMMIT)
                    && (cand != mood);

    assign dbg_sweep = (state_q == SWEEP);
    assign dbg_idx   = idx_q;

    // Debounce filter: candidate value plus saturating stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand <= 8'h00;
            sc   <= 4'd0;
        end else if (tick) begin
            if (emotion_in != cand) begin
                cand <= emotion_in;
                sc   <= 4'd1;
            end else if (sc < SC_MAX) begin
                sc <= sc + 4'd1;
            end
        end
    end

    // Committed mood register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mood <= 8'h00;
        end else if (commit) begin
            mood <= cand;
        end
    end

    // Display FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHOW;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Display FSM next state: a commit (re)starts the sweep, ticks advance it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raw     = mood;
        if (state_q == SWEEP) begin
            raw = 8'b1 << idx_q;
        end
        if (commit) begin
            state_d = SWEEP;
            idx_d   = 3'd0;
        end else if ((state_q == SWEEP) && tick) begin
            if (idx_q == 3'd7) begin
                state_d = SHOW;
                idx_d   = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Free-running dimming phase and registered LED output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm     <= 2'd0;
            led_out <= 8'h00;
        end else begin
            pwm <= pwm + 2'd1;
            if (awake || (pwm == 2'd0)) begin
                led_out <= raw;
            end else begin
                led_out <= 8'h00;
            end
        end
    end

    // Event channel: a commit always wins over acceptance; overwriting an
    // unaccepted event latches the drop flag until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_data  <= 8'h00;
            evt.evt_drop  <= 1'b0;
        end else if (commit) begin
            evt.evt_valid <= 1'b1;
            evt.evt_data  <= cand;
            if (evt.evt_valid && !evt.evt_ready) begin
                evt.evt_drop <= 1'b1;
            end
        end else if (evt.evt_valid && evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mood_display_sequencer.sv
// Directed bench for mood_display_sequencer with hand-computed expectations.
module tb_mood_display_sequencer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] emotion_in;
    logic       awake;
    logic [7:0] led_out;
    logic [7:0] mood;
    logic       dbg_sweep;
    logic [2:0] dbg_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];

    mood_display_sequencer_if evt_if ();

    mood_display_sequencer #(.STABLE_TICKS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .emotion_in (emotion_in),
        .awake      (awake),
        .led_out    (led_out),
        .mood       (mood),
        .evt        (evt_if.master),
        .dbg_sweep  (dbg_sweep),
        .dbg_idx    (dbg_idx)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, step past the edge, settle for sampling.
    task automatic cyc(input logic t, input logic [7:0] em);
        tick       = t;
        emotion_in = em;
        @(posedge clk);
        #1;
    endtask

    // Two reset clocks with tick toggling; pwm is 0 after the last one.
    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 8'hA5);
        cyc(1'b0, 8'h5A);
        rst        = 1'b0;
        tick       = 1'b0;
        emotion_in = 8'h00;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        awake            = 1'b1;
        evt_if.evt_ready = 1'b0;
        cyc(1'b1, 8'hA5);
        cyc(1'b0, 8'hA5);
        rst = 1'b0;
        cyc(1'b1, 8'h00);
        total_cnt++;
        if (led_out !== 8'h00) $display("FAIL reset_led got=%h exp=%h", led_out, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (mood !== 8'h00) $display("FAIL reset_mood got=%h exp=%h", mood, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop} !== 10'h000)
            $display("FAIL reset_evt got=%b/%h/%b exp=0/00/0",
                     evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop);
        else pass_cnt++;
        total_cnt++;
        if (dbg_sweep !== 1'b0) $display("FAIL reset_state got=%b exp=0", dbg_sweep);
        else pass_cnt++;
    endtask

    task automatic test_filter();
        do_reset();
        awake            = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (3) cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h00 || evt_if.evt_valid !== 1'b0)
            $display("FAIL filter_early got=%h/%b exp=00/0", mood, evt_if.evt_valid);
        else pass_cnt++;
        cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h12 || evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h12)
            $display("FAIL filter_commit got=%h/%b/%h exp=12/1/12",
                     mood, evt_if.evt_valid, evt_if.evt_data);
        else pass_cnt++;
        cyc(1'b1, 8'h12);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b0 || evt_if.evt_drop !== 1'b0)
            $display("FAIL filter_accept got=%b/%b exp=0/0", evt_if.evt_valid, evt_if.evt_drop);
        else pass_cnt++;
        repeat (4) cyc(1'b1, 8'h12);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b0)
            $display("FAIL filter_no_recommit got=%b exp=0", evt_if.evt_valid);
        else pass_cnt++;

        // Glitch on the 2nd tick restarts the count.
        do_reset();
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        repeat (3) cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h00) $display("FAIL glitch_hold got=%h exp=%h", mood, 8'h00);
        else pass_cnt++;
        cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h12) $display("FAIL glitch_commit got=%h exp=%h", mood, 8'h12);
        else pass_cnt++;
    endtask

    task automatic test_tick_gating();
        do_reset();
        cyc(1'b1, 8'h12);
        repeat (3) cyc(1'b0, 8'h34);
        repeat (2) cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h00) $display("FAIL gate_hold got=%h exp=%h", mood, 8'h00);
        else pass_cnt++;
        cyc(1'b1, 8'h12);
        total_cnt++;
        if (mood !== 8'h12) $display("FAIL gate_commit got=%h exp=%h", mood, 8'h12);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        do_reset();
        awake = 1'b1;
        repeat (4) cyc(1'b1, 8'h12);
        total_cnt++;
        if (dbg_sweep !== 1'b1 || dbg_idx !== 3'd0)
            $display("FAIL sweep_start got=%b/%0d exp=1/0", dbg_sweep, dbg_idx);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h12);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            cyc(1'b1, 8'h12);
            total_cnt++;
            if (led_out !== exp) $display("FAIL sweep_led got=%h exp=%h", led_out, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_restart();
        logic [7:0] exp;
        do_reset();
        awake = 1'b1;
        repeat (4) cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h40);
        cyc(1'b1, 8'h40);
        cyc(1'b1, 8'h40);
        total_cnt++;
        if (led_out !== 8'h04 || mood !== 8'h12)
            $display("FAIL restart_pre got=%h/%h exp=04/12", led_out, mood);
        else pass_cnt++;
        cyc(1'b1, 8'h40);
        total_cnt++;
        if (mood !== 8'h40 || dbg_idx !== 3'd0 || led_out !== 8'h08)
            $display("FAIL restart_commit got=%h/%0d/%h exp=40/0/08", mood, dbg_idx, led_out);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h40);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            cyc(1'b1, 8'h40);
            total_cnt++;
            if (led_out !== exp) $display("FAIL restart_led got=%h exp=%h", led_out, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_sleep();
        logic [7:0] exp;
        do_reset();
        awake = 1'b1;
        // Edges 1..13 after reset: commit at 4, sweep 5..12, SHOW at 13.
        repeat (13) cyc(1'b1, 8'h12);
        total_cnt++;
        if (led_out !== 8'h12) $display("FAIL sleep_pre got=%h exp=%h", led_out, 8'h12);
        else pass_cnt++;
        // Edges 14..21 use pwm phases 1,2,3,0,1,2,3,0.
        awake = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h12);
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            cyc(1'b0, 8'h12);
            total_cnt++;
            if (led_out !== exp) $display("FAIL sleep_dim got=%h exp=%h", led_out, exp);
            else pass_cnt++;
        end
        awake = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h12);
            total_cnt++;
            if (led_out !== 8'h12) $display("FAIL sleep_wake got=%h exp=%h", led_out, 8'h12);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        awake            = 1'b1;
        evt_if.evt_ready = 1'b0;
        repeat (4) cyc(1'b1, 8'h12);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h12 || evt_if.evt_drop !== 1'b0)
            $display("FAIL bp_first got=%b/%h/%b exp=1/12/0",
                     evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop);
        else pass_cnt++;
        repeat (3) cyc(1'b1, 8'h40);
        total_cnt++;
        if (evt_if.evt_data !== 8'h12) $display("FAIL bp_hold got=%h exp=%h", evt_if.evt_data, 8'h12);
        else pass_cnt++;
        cyc(1'b1, 8'h40);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h40 || evt_if.evt_drop !== 1'b1)
            $display("FAIL bp_overwrite got=%b/%h/%b exp=1/40/1",
                     evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop);
        else pass_cnt++;
        evt_if.evt_ready = 1'b1;
        cyc(1'b0, 8'h40);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b0 || evt_if.evt_drop !== 1'b1)
            $display("FAIL bp_drain got=%b/%b exp=0/1", evt_if.evt_valid, evt_if.evt_drop);
        else pass_cnt++;
        cyc(1'b0, 8'h40);
        total_cnt++;
        if (evt_if.evt_drop !== 1'b1) $display("FAIL bp_sticky got=%b exp=1", evt_if.evt_drop);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // Acceptance and a new commit on the same edge: no drop.
        do_reset();
        evt_if.evt_ready = 1'b0;
        repeat (4) cyc(1'b1, 8'h12);
        repeat (3) cyc(1'b1, 8'h40);
        evt_if.evt_ready = 1'b1;
        cyc(1'b1, 8'h40);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== 8'h40 || evt_if.evt_drop !== 1'b0)
            $display("FAIL b2b_commit got=%b/%h/%b exp=1/40/0",
                     evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop);
        else pass_cnt++;
        cyc(1'b0, 8'h40);
        total_cnt++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL b2b_accept got=%b exp=0", evt_if.evt_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        evt_if.evt_ready = 1'b0;
        repeat (4) cyc(1'b1, 8'h12);
        repeat (3) cyc(1'b1, 8'h40);
        cyc(1'b1, 8'h40);
        repeat (2) cyc(1'b1, 8'h40);
        do_reset();
        total_cnt++;
        if (mood !== 8'h00 || led_out !== 8'h00 || dbg_sweep !== 1'b0)
            $display("FAIL midrst_disp got=%h/%h/%b exp=00/00/0", mood, led_out, dbg_sweep);
        else pass_cnt++;
        total_cnt++;
        if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop} !== 10'h000)
            $display("FAIL midrst_evt got=%b/%h/%b exp=0/00/0",
                     evt_if.evt_valid, evt_if.evt_data, evt_if.evt_drop);
        else pass_cnt++;
    endtask

    initial begin
        rst              = 1'b1;
        tick             = 1'b0;
        emotion_in       = 8'h00;
        awake            = 1'b1;
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_filter();
        test_tick_gating();
        test_sweep();
        test_restart();
        test_sleep();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
